status_reg_unit: RTL and testbench
==================================

// Module: status_reg_unit
// PURPOSE
//  Holds CPU status flags C/Z/N and interrupt enable IE directly downstream of the ALU.
//  - Captures ALU cout/zout/nout on flag-writing instructions.
//  - Feeds the registered C back to the ALU cin.
//  - Saves/restores {IE,N,Z,C} on interrupt entry/RETI via a small shadow LIFO, so nested IRQs preserve context.
// PARAMETERS
//  STK_DEPTH   4   shadow LIFO entries (>=1); pointer width $clog2(STK_DEPTH+1)
//  SR_ADDR     8'h0F  I/O address of status byte (used only with SR_IO_EN)
// PORTS
//  clk         in   1  system clock, all state on rising edge
//  rst         in   1  asynchronous, active-high reset
//  alu_c       in   1  ALU carry out
//  alu_z       in   1  ALU zero out
//  alu_n       in   1  ALU negative/greater out
//  flag_we     in   1  capture alu_c/z/n this cycle
//  sei         in   1  set IE
//  cli         in   1  clear IE
//  irq_enter   in   1  interrupt accepted: push context, clear IE
//  reti        in   1  return from interrupt: pop context
//  c_flag      out  1  C register (also drives ALU cin)
//  z_flag      out  1  Z register
//  n_flag      out  1  N register
//  ie          out  1  IE register
//  stk_full    out  1  LIFO holds STK_DEPTH entries
//  stk_empty   out  1  LIFO holds 0 entries
//  stk_err     out  1  sticky: push-on-full or pop-on-empty occurred
// BEHAVIOUR
//  - Reset (async): C=Z=N=IE=0, LIFO empty, stk_err=0; io_rdata reflects these.
//  - All updates are registered; outputs change one cycle after the qualifying input. No combinational path from inputs to outputs except io_rdata (address decode).
//  - Status byte: bit0 C, bit1 Z, bit2 N, bit3 IE, bits7:4 read 0.
//  - Priority per cycle: irq_enter > reti > io write > (flag_we, sei/cli).
//  - irq_enter:
//    - Not full: push {IE,N,Z,C}, sp+1, IE<=0; C/Z/N unchanged.
//    - Full: no push, sp held, IE<=0, stk_err<=1.
//    - flag_we, sei, cli and reti in the same cycle are ignored.
//  - reti:
//    - Not empty: pop; C,Z,N,IE <= popped entry; sp-1.
//    - Empty: flags unchanged, IE<=1, stk_err<=1.
//    - Other updates in the same cycle are ignored.
//  - flag_we alone: C,Z,N <= alu_c,alu_z,alu_n.
//  - sei/cli:
//    - Affect IE only; may coincide with flag_we, and both apply.
//    - sei and cli together: cli wins.
//  - stk_full/stk_empty: decoded from sp registers, so they track sp the cycle after push/pop. stk_err is cleared only by rst (or an IO write, see below).
//  - Reset mid-operation: asserting rst during any push/pop leaves the LIFO empty; no partial entry survives.
// CONFIGURATION
//  SR_IO_EN defined: adds the following ports.
//    io_addr   in   8
//    io_we     in   1
//    io_wdata  in   8
//    io_rdata  out  8
//  - io_rdata = status byte when io_addr==SR_ADDR, else 0 (combinational).
//  - io_we at SR_ADDR loads C/Z/N/IE from wdata[3:0] next cycle, writes stk_err<=wdata[7]&stk_err (write 0 clears), and overrides flag_we/sei/cli.
//  SR_IO_EN undefined: ports absent; status is reachable only via flags/ie outputs, and stk_err is cleared only by rst.
// STRUCTURE
//  - Shared header status_defs.vh: localparams SR_C=0, SR_Z=1, SR_N=2, SR_IE=3, SR_W=4 (context width).
//  - Sub-module status_shadow_stack:
//    - Parameterised LIFO of SR_W-bit entries, depth STK_DEPTH.
//    - Ports push/pop/din/dout/full/empty/ovf/unf; async active-high reset.
//  - Top holds flag regs, priority mux, stk_err and IO decode.
// TESTING
//  1. rst pulse mid-cycle -> all flags 0, stk_empty=1, stk_full=0, stk_err=0 immediately (async).
//  2. flag_we with alu_c/z/n=1/0/1 -> next cycle c_flag=1,z_flag=0,n_flag=1; flag_we=0 next -> held.
//  3. With C=1,Z=0,N=0,IE=1: irq_enter -> IE=0, flags held.
//     Then flag_we with c/z/n=0/1/1, then reti -> C=1,Z=0,N=0,IE=1, stk_empty=1.
//  4. Push STK_DEPTH+1 times (4+1=5) -> stk_full=1 after 4th, stk_err=1 after 5th, IE=0.
//     Then 4 retis restore entries in reverse order.
//  5. reti on empty -> flags unchanged, IE=1, stk_err=1.
//     Also: irq_enter+reti+flag_we in one cycle -> push only.
//  6. SR_IO_EN:
//     - io write 8'h0B at SR_ADDR -> C=1,Z=1,N=0,IE=1.
//     - Readback 8'h0B at SR_ADDR; other addresses -> 8'h00.
//     - Write bit7=0 with stk_err=1 -> stk_err=0.

Source files
------------

// File: rtl/status_reg_unit_pkg.sv
// Shared definitions for the status register unit: status bit positions,
// saved-context layout and update-source selection.
package status_reg_unit_pkg;

  localparam int unsigned SR_C  = 0;
  localparam int unsigned SR_Z  = 1;
  localparam int unsigned SR_N  = 2;
  localparam int unsigned SR_IE = 3;
  localparam int unsigned SR_W  = 4;

  // Field order puts C at bit 0, matching the status byte layout.
  typedef struct packed {
    logic ie;
    logic n;
    logic z;
    logic c;
  } sr_ctx_t;

  typedef enum logic [1:0] {
    UPD_IRQ,
    UPD_RETI,
    UPD_IO,
    UPD_LOCAL
  } sr_upd_e;

  function automatic logic [7:0] status_byte(input sr_ctx_t ctx);
    return {4'b0000, ctx};
  endfunction

endpackage

// File: rtl/status_reg_unit_if.sv
// Bus between the ALU/control side and the status register unit.
// With SR_IO_EN defined the I/O status-byte access signals are included.
interface status_reg_unit_if;
  logic       alu_c;
  logic       alu_z;
  logic       alu_n;
  logic       flag_we;
  logic       sei;
  logic       cli;
  logic       irq_enter;
  logic       reti;
  logic       c_flag;
  logic       z_flag;
  logic       n_flag;
  logic       ie;
  logic       stk_full;
  logic       stk_empty;
  logic       stk_err;
`ifdef SR_IO_EN
  logic [7:0] io_addr;
  logic       io_we;
  logic [7:0] io_wdata;
  logic [7:0] io_rdata;

  modport master (
    output alu_c, alu_z, alu_n, flag_we, sei, cli, irq_enter, reti,
    output io_addr, io_we, io_wdata,
    input  c_flag, z_flag, n_flag, ie, stk_full, stk_empty, stk_err,
    input  io_rdata
  );
  modport slave (
    input  alu_c, alu_z, alu_n, flag_we, sei, cli, irq_enter, reti,
    input  io_addr, io_we, io_wdata,
    output c_flag, z_flag, n_flag, ie, stk_full, stk_empty, stk_err,
    output io_rdata
  );
`else
  modport master (
    output alu_c, alu_z, alu_n, flag_we, sei, cli, irq_enter, reti,
    input  c_flag, z_flag, n_flag, ie, stk_full, stk_empty, stk_err
  );
  modport slave (
    input  alu_c, alu_z, alu_n, flag_we, sei, cli, irq_enter, reti,
    output c_flag, z_flag, n_flag, ie, stk_full, stk_empty, stk_err
  );
`endif
endinterface

// File: rtl/status_reg_unit_shadow_stack.sv
// Shadow LIFO for saved status contexts; push wins over a simultaneous pop.
// ovf/unf flag a push on full / pop on empty in the current cycle.
module status_shadow_stack
  import status_reg_unit_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 4,
  parameter int unsigned W         = SR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty,
  output logic         ovf,
  output logic         unf
);

  localparam int unsigned PW   = $clog2(STK_DEPTH + 1);
  localparam int unsigned AW   = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;
  localparam int unsigned NENT = 1 << AW;

  logic [W-1:0]  mem [0:NENT-1];
  logic [PW-1:0] sp;
  logic [PW-1:0] top;

  assign full  = (sp == PW'(STK_DEPTH));
  assign empty = (sp == '0);
  assign top   = sp - PW'(1);
  assign dout  = mem[top[AW-1:0]];
  assign ovf   = push & full;
  assign unf   = pop & ~push & empty;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sp <= '0;
      for (int unsigned i = 0; i < NENT; i++) begin
        mem[i] <= '0;
      end
    end else if (push) begin
      if (!full) begin
        mem[sp[AW-1:0]] <= din;
        sp              <= sp + PW'(1);
      end
    end else if (pop && !empty) begin
      sp <= sp - PW'(1);
    end
  end

endmodule

// File: rtl/status_reg_unit.sv
// CPU status flags C/Z/N/IE with interrupt context save/restore.
// Optional I/O-mapped status byte when SR_IO_EN is defined.
module status_reg_unit
  import status_reg_unit_pkg::*;
#(
  parameter int unsigned STK_DEPTH = 4,
  parameter logic [7:0]  SR_ADDR   = 8'h0F
) (
  input logic              clk,
  input logic              rst,
  status_reg_unit_if.slave sr
);

  sr_ctx_t         ctx;
  sr_ctx_t         pop_ctx;
  logic [SR_W-1:0] stk_dout;
  logic            stk_err;
  logic            full;
  logic            empty;
  logic            ovf;
  logic            unf;
  logic            io_hit;
  sr_upd_e         upd;

  status_shadow_stack #(
    .STK_DEPTH(STK_DEPTH),
    .W        (SR_W)
  ) u_stack (
    .clk  (clk),
    .rst  (rst),
    .push (sr.irq_enter),
    .pop  (sr.reti),
    .din  (ctx),
    .dout (stk_dout),
    .full (full),
    .empty(empty),
    .ovf  (ovf),
    .unf  (unf)
  );

  assign pop_ctx = sr_ctx_t'(stk_dout);

`ifdef SR_IO_EN
  assign io_hit      = sr.io_we && (sr.io_addr == SR_ADDR);
  assign sr.io_rdata = (sr.io_addr == SR_ADDR) ? status_byte(ctx) : '0;
`else
  assign io_hit = 1'b0;
`endif

  always_comb begin
    upd = UPD_LOCAL;
    if (sr.irq_enter)  upd = UPD_IRQ;
    else if (sr.reti)  upd = UPD_RETI;
    else if (io_hit)   upd = UPD_IO;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ctx     <= '0;
      stk_err <= 1'b0;
    end else begin
      unique case (upd)
        UPD_IRQ: begin
          ctx.ie <= 1'b0;
          if (ovf) stk_err <= 1'b1;
        end
        UPD_RETI: begin
          // An empty-stack return still re-enables interrupts.
          if (unf) begin
            ctx.ie  <= 1'b1;
            stk_err <= 1'b1;
          end else begin
            ctx <= pop_ctx;
          end
        end
        UPD_IO: begin
`ifdef SR_IO_EN
          ctx     <= sr_ctx_t'(sr.io_wdata[SR_IE:SR_C]);
          stk_err <= sr.io_wdata[7] & stk_err;
`endif
        end
        default: begin
          if (sr.flag_we) begin
            ctx.c <= sr.alu_c;
            ctx.z <= sr.alu_z;
            ctx.n <= sr.alu_n;
          end
          if (sr.cli)      ctx.ie <= 1'b0;
          else if (sr.sei) ctx.ie <= 1'b1;
        end
      endcase
    end
  end

  assign sr.c_flag    = ctx.c;
  assign sr.z_flag    = ctx.z;
  assign sr.n_flag    = ctx.n;
  assign sr.ie        = ctx.ie;
  assign sr.stk_full  = full;
  assign sr.stk_empty = empty;
  assign sr.stk_err   = stk_err;

endmodule

// File: tb/tb_status_reg_unit.sv
// Testbench for status_reg_unit: directed scenarios plus random cycles
// checked against a queue-based reference model.
module tb_status_reg_unit;

  localparam int unsigned DEPTH = 4;
  localparam logic [7:0]  ADDR  = 8'h0F;

  logic clk = 1'b0;
  logic rst = 1'b0;

  status_reg_unit_if bus ();

  status_reg_unit #(
    .STK_DEPTH(DEPTH),
    .SR_ADDR  (ADDR)
  ) dut (
    .clk(clk),
    .rst(rst),
    .sr (bus)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_mis = 0;

  // Model state: bit0 C, bit1 Z, bit2 N, bit3 IE.
  logic [3:0] m_ctx;
  logic       m_err;
  logic [3:0] m_stk [$];

  task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_mis++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.alu_c = 0; bus.alu_z = 0; bus.alu_n = 0;
    bus.flag_we = 0; bus.sei = 0; bus.cli = 0;
    bus.irq_enter = 0; bus.reti = 0;
`ifdef SR_IO_EN
    bus.io_addr = 8'h00; bus.io_we = 0; bus.io_wdata = 8'h00;
`endif
  endtask

  task automatic model_reset();
    m_ctx = 4'h0;
    m_err = 1'b0;
    m_stk.delete();
  endtask

  task automatic model_cycle();
    logic io_w;
    io_w = 1'b0;
`ifdef SR_IO_EN
    io_w = bus.io_we && (bus.io_addr == ADDR);
`endif
    if (bus.irq_enter) begin
      if (m_stk.size() < DEPTH) m_stk.push_back(m_ctx);
      else m_err = 1'b1;
      m_ctx[3] = 1'b0;
    end else if (bus.reti) begin
      if (m_stk.size() > 0) m_ctx = m_stk.pop_back();
      else begin
        m_ctx[3] = 1'b1;
        m_err    = 1'b1;
      end
    end else if (io_w) begin
`ifdef SR_IO_EN
      m_ctx = bus.io_wdata[3:0];
      m_err = bus.io_wdata[7] & m_err;
`endif
    end else begin
      if (bus.flag_we) m_ctx[2:0] = {bus.alu_n, bus.alu_z, bus.alu_c};
      if (bus.cli) m_ctx[3] = 1'b0;
      else if (bus.sei) m_ctx[3] = 1'b1;
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".c"},     bus.c_flag,    m_ctx[0]);
    check({tag, ".z"},     bus.z_flag,    m_ctx[1]);
    check({tag, ".n"},     bus.n_flag,    m_ctx[2]);
    check({tag, ".ie"},    bus.ie,        m_ctx[3]);
    check({tag, ".full"},  bus.stk_full,  m_stk.size() == DEPTH);
    check({tag, ".empty"}, bus.stk_empty, m_stk.size() == 0);
    check({tag, ".err"},   bus.stk_err,   m_err);
`ifdef SR_IO_EN
    check({tag, ".rdata"}, bus.io_rdata, (bus.io_addr == ADDR) ? {4'h0, m_ctx} : 8'h00);
`endif
  endtask

  // Inputs are set at posedge+1; model and DUT both see them at the next edge.
  task automatic step(input string tag);
    model_cycle();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  // Asserts rst partway through a cycle with a push pending.
  task automatic mid_reset(input string tag);
    bus.irq_enter = 1'b1;
    bus.flag_we   = 1'b1;
    #3 rst = 1'b1;
    #1;
    model_reset();
    check_all(tag);
    #2 rst = 1'b0;
    idle();
  endtask

  initial begin
    idle();
    model_reset();
    #1 rst = 1'b1;
    #1 check_all("reset");
    #6 rst = 1'b0;

    // Flag capture then hold
    bus.flag_we = 1; bus.alu_c = 1; bus.alu_z = 0; bus.alu_n = 1;
    step("t2_cap");
    check("t2_c", bus.c_flag, 1); check("t2_z", bus.z_flag, 0); check("t2_n", bus.n_flag, 1);
    idle();
    step("t2_hold");
    check("t2_hold_c", bus.c_flag, 1); check("t2_hold_n", bus.n_flag, 1);

    // Single interrupt save/restore
    bus.flag_we = 1; bus.alu_c = 1; bus.alu_z = 0; bus.alu_n = 0; bus.sei = 1;
    step("t3_setup");
    idle(); bus.irq_enter = 1;
    step("t3_irq");
    check("t3_irq_ie", bus.ie, 0); check("t3_irq_c", bus.c_flag, 1);
    idle(); bus.flag_we = 1; bus.alu_c = 0; bus.alu_z = 1; bus.alu_n = 1;
    step("t3_isr");
    idle(); bus.reti = 1;
    step("t3_reti");
    check("t3_c", bus.c_flag, 1); check("t3_z", bus.z_flag, 0); check("t3_n", bus.n_flag, 0);
    check("t3_ie", bus.ie, 1); check("t3_empty", bus.stk_empty, 1);

    // Fill the stack past its depth, then unwind
    for (int unsigned i = 0; i < DEPTH + 1; i++) begin
      logic [2:0] v;
      v = 3'(i);
      idle(); bus.flag_we = 1; bus.sei = 1;
      bus.alu_c = v[0]; bus.alu_z = v[1]; bus.alu_n = v[2];
      step("t4_flags");
      idle(); bus.irq_enter = 1;
      step("t4_push");
      if (i == DEPTH - 1) check("t4_full", bus.stk_full, 1);
      if (i == DEPTH)     check("t4_err", bus.stk_err, 1);
    end
    check("t4_ie", bus.ie, 0);
    idle(); bus.reti = 1;
    step("t4_pop_first");
    check("t4_pop_c", bus.c_flag, 1); check("t4_pop_z", bus.z_flag, 1); check("t4_pop_n", bus.n_flag, 0);
    for (int unsigned i = 1; i < DEPTH; i++) step("t4_pop");
    check("t4_last_c", bus.c_flag, 0); check("t4_last_ie", bus.ie, 1);
    check("t4_last_empty", bus.stk_empty, 1);

    // Empty reti and simultaneous irq/reti/flag_we
    idle();
    mid_reset("t5_rst");
    bus.flag_we = 1; bus.alu_c = 1; bus.alu_z = 1; bus.alu_n = 0;
    step("t5_setup");
    idle(); bus.reti = 1;
    step("t5_reti_empty");
    check("t5_c", bus.c_flag, 1); check("t5_ie", bus.ie, 1); check("t5_err", bus.stk_err, 1);
    idle(); bus.irq_enter = 1; bus.reti = 1; bus.flag_we = 1; bus.alu_n = 1;
    step("t5_combo");
    check("t5_combo_empty", bus.stk_empty, 0); check("t5_combo_n", bus.n_flag, 0);
    check("t5_combo_ie", bus.ie, 0);

`ifdef SR_IO_EN
    idle(); bus.io_we = 1; bus.io_addr = ADDR; bus.io_wdata = 8'h8B; bus.flag_we = 1;
    step("t6_wr_keep");
    check("t6_keep_err", bus.stk_err, 1);
    idle(); bus.io_we = 1; bus.io_addr = ADDR; bus.io_wdata = 8'h0B;
    step("t6_wr");
    check("t6_c", bus.c_flag, 1); check("t6_z", bus.z_flag, 1);
    check("t6_n", bus.n_flag, 0); check("t6_ie", bus.ie, 1);
    check("t6_err_clr", bus.stk_err, 0);
    idle(); bus.io_addr = ADDR;
    #1 check("t6_rd_hit", bus.io_rdata, 8'h0B);
    bus.io_addr = 8'h10;
    #1 check("t6_rd_miss", bus.io_rdata, 8'h00);
    idle();
    step("t6_idle");
`endif

    // Random traffic
    for (int unsigned k = 0; k < 600; k++) begin
      idle();
      bus.alu_c     = 1'($urandom);
      bus.alu_z     = 1'($urandom);
      bus.alu_n     = 1'($urandom);
      bus.flag_we   = ($urandom % 2) == 0;
      bus.sei       = ($urandom % 4) == 0;
      bus.cli       = ($urandom % 4) == 0;
      bus.irq_enter = ($urandom % 6) == 0;
      bus.reti      = ($urandom % 6) == 0;
`ifdef SR_IO_EN
      bus.io_addr   = ($urandom % 2) ? ADDR : 8'($urandom);
      bus.io_we     = ($urandom % 8) == 0;
      bus.io_wdata  = 8'($urandom);
`endif
      if (k == 300) mid_reset("rnd_rst");
      else step("rnd");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
